// File: rtl/grn_step_ctrl.sv
// Step sequencer for a Boolean-network node array: load, two-phase update, fixed-point/timeout check.
// Optional trace port: define GRN_STEP_CTRL_TRACE_EN to add trace_valid/trace_state.
module grn_step_ctrl #(
    parameter int N_NODES = 8,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [STEP_W-1:0]  max_steps,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_state,
    output logic [STEP_W-1:0]  res_steps,
`ifdef GRN_STEP_CTRL_TRACE_EN
    output logic               trace_valid,
    output logic [N_NODES-1:0] trace_state,
`endif
    output logic               res_timeout
);

    // state   | meaning
    // IDLE    | waiting for start
    // LOAD    | reset_nos pulse, nodes take init_state
    // PH0     | start_s0 strobe
    // WAIT0   | settle after phase 0
    // PH1     | start_s1 strobe
    // WAIT1   | settle after phase 1
    // CHECK   | count step, test fixed point / budget
    // RESULT  | hold result until host accepts
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PH0, S_WAIT0, S_PH1, S_WAIT1, S_CHECK, S_RESULT
    } state_t;

    state_t             state_q, state_d;
    logic [N_NODES-1:0] init_q, init_d;
    logic [STEP_W-1:0]  max_q, max_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [N_NODES-1:0] prev_q, prev_d;
    logic [N_NODES-1:0] res_state_q, res_state_d;
    logic [STEP_W-1:0]  res_steps_q, res_steps_d;
    logic               res_timeout_q, res_timeout_d;

    logic [STEP_W-1:0]  steps_inc;
    logic [STEP_W-1:0]  eff_max;
    logic               fixed_pt;

    // A zero budget still runs one step.
    assign steps_inc = (steps_q == {STEP_W{1'b1}}) ? steps_q : steps_q + STEP_W'(1);
    assign eff_max   = (max_q == '0) ? STEP_W'(1) : max_q;
    assign fixed_pt  = (s0_vec == prev_q) && (s1_vec == s0_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            init_q        <= '0;
            max_q         <= '0;
            steps_q       <= '0;
            prev_q        <= '0;
            res_state_q   <= '0;
            res_steps_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_q        <= init_d;
            max_q         <= max_d;
            steps_q       <= steps_d;
            prev_q        <= prev_d;
            res_state_q   <= res_state_d;
            res_steps_q   <= res_steps_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_d        = init_q;
        max_d         = max_q;
        steps_d       = steps_q;
        prev_d        = prev_q;
        res_state_d   = res_state_q;
        res_steps_d   = res_steps_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    init_d  = init_vec;
                    max_d   = max_steps;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                steps_d = '0;
                prev_d  = init_q;
                state_d = S_PH0;
            end
            S_PH0:   state_d = S_WAIT0;
            S_WAIT0: state_d = S_PH1;
            S_PH1:   state_d = S_WAIT1;
            S_WAIT1: state_d = S_CHECK;
            S_CHECK: begin
                steps_d = steps_inc;
                // Fixed point takes priority over an expiring budget.
                if (fixed_pt) begin
                    res_state_d   = s0_vec;
                    res_steps_d   = steps_inc;
                    res_timeout_d = 1'b0;
                    state_d       = S_RESULT;
                end else if (steps_inc >= eff_max) begin
                    res_state_d   = s0_vec;
                    res_steps_d   = steps_inc;
                    res_timeout_d = 1'b1;
                    state_d       = S_RESULT;
                end else begin
                    prev_d  = s0_vec;
                    state_d = S_PH0;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_state_d   = '0;
                    res_steps_d   = '0;
                    res_timeout_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked while rst is high so nothing reaches the nodes in the reset cycle.
    always_comb begin
        reset_nos   = (state_q == S_LOAD) && !rst;
        init_state  = (state_q == S_LOAD) ? init_q : '0;
        start_s0    = (state_q == S_PH0) && !rst;
        start_s1    = (state_q == S_PH1) && !rst;
        busy        = (state_q != S_IDLE);
        res_valid   = (state_q == S_RESULT);
        res_state   = res_state_q;
        res_steps   = res_steps_q;
        res_timeout = res_timeout_q;
    end

`ifdef GRN_STEP_CTRL_TRACE_EN
    always_comb begin
        trace_valid = (state_q == S_CHECK);
        trace_state = (state_q == S_CHECK) ? s0_vec : '0;
    end
`endif

endmodule

// File: tb/tb_grn_step_ctrl.sv
// Bench for grn_step_ctrl: node-array stub, directed table, random runs against a step-level model.
// Also exercises the trace port when GRN_STEP_CTRL_TRACE_EN is defined.
module tb_grn_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  init_vec = '0;
    logic [15:0] max_steps = '0;
    logic        reset_nos, start_s0, start_s1, busy, res_valid, res_timeout;
    logic [7:0]  init_state, res_state;
    logic [15:0] res_steps;
    logic [7:0]  s0_vec, s1_vec;
    logic        res_ready = 1'b0;
`ifdef GRN_STEP_CTRL_TRACE_EN
    logic        trace_valid;
    logic [7:0]  trace_state;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s0_cnt = 0, s1_cnt = 0, rn_cnt = 0, tr_cnt = 0;
    int s0_cyc[$];
    int node_mode = 0;
    logic [7:0] node_mask = '0;

    always #5 clk = ~clk;

    grn_step_ctrl #(.N_NODES(8), .STEP_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec), .max_steps(max_steps),
        .reset_nos(reset_nos), .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
        .s0_vec(s0_vec), .s1_vec(s1_vec), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_state(res_state), .res_steps(res_steps),
`ifdef GRN_STEP_CTRL_TRACE_EN
        .trace_valid(trace_valid), .trace_state(trace_state),
`endif
        .res_timeout(res_timeout)
    );

    function automatic logic [7:0] node_f(input logic [7:0] x, input int mode, input logic [7:0] m);
        case (mode)
            1:       return x ^ m;
            2:       return x & m;
            default: return x;
        endcase
    endfunction

    // Node array stub: s0 takes f(s1) on start_s0, s1 copies s0 on start_s1.
    always @(posedge clk) begin
        if (rst) begin
            s0_vec <= '0;
            s1_vec <= '0;
        end else if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
        end else if (start_s0) begin
            s0_vec <= node_f(s1_vec, node_mode, node_mask);
        end else if (start_s1) begin
            s1_vec <= s0_vec;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (start_s0) begin s0_cnt++; s0_cyc.push_back(cyc); end
        if (start_s1) s1_cnt++;
        if (reset_nos) rn_cnt++;
        if (start_s0 || start_s1 || reset_nos) begin
            checks++;
            if (int'(start_s0) + int'(start_s1) + int'(reset_nos) > 1) begin
                errors++;
                $display("FAIL strobe_excl: s0=%0b s1=%0b rn=%0b required at most one", start_s0, start_s1, reset_nos);
            end
        end
`ifdef GRN_STEP_CTRL_TRACE_EN
        if (trace_valid) begin
            tr_cnt++;
            checks++;
            if (trace_state !== s0_vec) begin
                errors++;
                $display("FAIL trace_state: got %h required %h", trace_state, s0_vec);
            end
        end
`endif
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Step-level reference: iterate the node function until repeat or budget end.
    task automatic model(input logic [7:0] init, input logic [15:0] maxs, input int mode,
                         input logic [7:0] m, output logic [7:0] st, output logic [15:0] steps,
                         output logic to);
        logic [7:0] s, prev;
        int lim;
        s = init; prev = init;
        lim = (maxs == 0) ? 1 : int'(maxs);
        st = '0; steps = '0; to = 1'b0;
        for (int k = 1; k <= lim; k++) begin
            s = node_f(s, mode, m);
            if (s == prev) begin st = s; steps = 16'(k); to = 1'b0; return; end
            if (k == lim)  begin st = s; steps = 16'(k); to = 1'b1; return; end
            prev = s;
        end
    endtask

    task automatic start_run(input logic [7:0] init, input logic [15:0] maxs,
                             input int mode, input logic [7:0] m, output int c0);
        node_mode = mode; node_mask = m;
        s0_cnt = 0; s1_cnt = 0; rn_cnt = 0; tr_cnt = 0;
        s0_cyc.delete();
        init_vec = init; max_steps = maxs; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        init_vec = ~init;
        max_steps = 16'hFFFF;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (res_valid) begin ok = 1'b1; return; end
            @(negedge clk);
        end
        errors++;
        $display("FAIL res_valid_timeout: got 0 required 1 within 2000 cycles");
    endtask

    task automatic do_run(input string nm, input logic [7:0] init, input logic [15:0] maxs,
                          input int mode, input logic [7:0] m, input logic [7:0] e_st,
                          input logic [15:0] e_steps, input logic e_to);
        int c0;
        bit ok;
        start_run(init, maxs, mode, m, c0);
        wait_valid(ok);
        if (!ok) begin
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            return;
        end
        chk({nm, ".state"}, 32'(res_state), 32'(e_st));
        chk({nm, ".steps"}, 32'(res_steps), 32'(e_steps));
        chk({nm, ".timeout"}, 32'(res_timeout), 32'(e_to));
        chk({nm, ".latency"}, 32'(cyc - c0), 32'(2 + 5 * int'(e_steps)));
        chk({nm, ".n_s0"}, 32'(s0_cnt), 32'(e_steps));
        chk({nm, ".n_s1"}, 32'(s1_cnt), 32'(e_steps));
        chk({nm, ".n_load"}, 32'(rn_cnt), 32'd1);
`ifdef GRN_STEP_CTRL_TRACE_EN
        chk({nm, ".n_trace"}, 32'(tr_cnt), 32'(e_steps));
`endif
        for (int i = 1; i < s0_cyc.size(); i++)
            chk({nm, ".s0_spacing"}, 32'(s0_cyc[i] - s0_cyc[i-1]), 32'd5);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, ".busy_after"}, 32'(busy), 32'd0);
        chk({nm, ".res_cleared"}, {res_valid, res_timeout, res_steps, res_state}, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  init;
        logic [15:0] maxs;
        int          mode;
        logic [7:0]  mask;
        logic [7:0]  e_st;
        logic [15:0] e_steps;
        logic        e_to;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int c0;
        bit ok;
        logic [7:0]  m_st;
        logic [15:0] m_steps;
        logic        m_to;
        logic [7:0]  r_init, r_mask;
        logic [15:0] r_max;
        int          r_mode;

        tbl[0] = '{8'hA5, 16'd10, 0, 8'h00, 8'hA5, 16'd1, 1'b0}; // identity: fixed at step 1
        tbl[1] = '{8'h3C, 16'd4,  1, 8'h01, 8'h3C, 16'd4, 1'b1}; // toggle bit0, budget 4
        tbl[2] = '{8'h00, 16'd0,  1, 8'h01, 8'h01, 16'd1, 1'b1}; // zero budget runs one step
        tbl[3] = '{8'hF0, 16'd8,  2, 8'h3C, 8'h30, 16'd2, 1'b0}; // converges at step 2
        tbl[4] = '{8'hF0, 16'd2,  2, 8'h3C, 8'h30, 16'd2, 1'b0}; // fixed point and budget together
        tbl[5] = '{8'h81, 16'd3,  1, 8'h80, 8'h01, 16'd3, 1'b1}; // 3-step toggling run
        tbl[6] = '{8'h5A, 16'd1,  0, 8'h00, 8'h5A, 16'd1, 1'b0}; // budget 1, fixed wins

        repeat (3) @(negedge clk);
        chk("reset.outputs", {busy, res_valid, reset_nos, start_s0, start_s1, res_timeout}, 32'd0);
        chk("reset.vectors", {init_state, res_state, res_steps}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++)
            do_run($sformatf("tbl%0d", i), tbl[i].init, tbl[i].maxs, tbl[i].mode, tbl[i].mask,
                   tbl[i].e_st, tbl[i].e_steps, tbl[i].e_to);

        for (int i = 0; i < 30; i++) begin
            r_init = 8'($urandom);
            r_mask = 8'($urandom);
            r_mode = int'($urandom_range(0, 2));
            r_max  = 16'($urandom_range(0, 6));
            model(r_init, r_max, r_mode, r_mask, m_st, m_steps, m_to);
            do_run($sformatf("rnd%0d", i), r_init, r_max, r_mode, r_mask, m_st, m_steps, m_to);
        end

        // Back-pressure: result held while ready is low; start pulses ignored.
        start_run(8'h55, 16'd3, 1, 8'h01, c0);
        wait_valid(ok);
        for (int i = 0; i < 7; i++) begin
            start = (i % 2 == 0);
            init_vec = 8'hFF;
            max_steps = 16'd9;
            @(negedge clk);
            chk("hold.valid", 32'(res_valid), 32'd1);
            chk("hold.result", {res_timeout, res_steps, res_state}, {7'd0, 1'b1, 16'd3, 8'h54});
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hold.busy_drop", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold.no_reload", 32'(rn_cnt), 32'd1);
        chk("hold.still_idle", 32'(busy), 32'd0);

        // Reset during WAIT0 of step 3, then a clean run.
        start_run(8'h0F, 16'd10, 1, 8'h01, c0);
        for (int i = 0; i < 200 && s0_cnt < 3; i++) @(negedge clk);
        chk("rst.reach_step3", 32'(s0_cnt), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.outputs", {busy, res_valid, reset_nos, start_s0, start_s1, res_timeout}, 32'd0);
        chk("rst.vectors", {init_state, res_state, res_steps}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.idle", 32'(busy), 32'd0);
        do_run("post_rst", 8'hC3, 16'd5, 0, 8'h00, 8'hC3, 16'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
